siu_arbiter: RTL and testbench

- Round-robin scheduler that shares one combinational sigmoid LUT between NREQ neuron requesters.
- Accepts signed pre-activation values over a valid/ready handshake.
- Encodes each value into the LUT's address/sign/overflow inputs, registers the LUT output and returns it tagged with the requester id.
- Sits between the neuron accumulators and the single sigmoid LUT instance in the SIU.

---
 rtl/siu_arbiter_if.sv | 24 ++
 rtl/siu_arbiter.sv | 105 ++++++++++
 tb/tb_siu_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/siu_arbiter_if.sv
// Request/response bundle between the neuron accumulators and the sigmoid arbiter.
// The arbiter takes the slave modport; requesters and the result consumer take master.
interface siu_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [11*NREQ-1:0] req_x;
  logic [NREQ-1:0]    req_ready;
  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [7:0]         resp_data;

  modport master (
    output req_valid, req_x, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_data
  );

  modport slave (
    input  req_valid, req_x, resp_ready,
    output req_ready, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/siu_arbiter.sv
// Round-robin scheduler sharing one combinational sigmoid LUT among NREQ requesters.
// Two stages: S1 holds the encoded LUT inputs, S2 captures the LUT output.
module siu_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic           clk,
  input  logic           rst,
  siu_arbiter_if.slave   bus,
  output logic [8:0]     lut_addr,
  output logic           lut_sign,
  output logic           lut_ovf,
  input  logic [7:0]     lut_data,
  output logic           busy
);

  logic            stall;
  logic            accept;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic [10:0]     grant_x;
  logic [IDW-1:0]  ptr_q, ptr_d;

  logic            s1_valid_q;
  logic [IDW-1:0]  s1_id_q;
  logic [8:0]      lut_addr_q;
  logic            lut_sign_q;
  logic            lut_ovf_q;
  logic            resp_valid_q;
  logic [IDW-1:0]  resp_id_q;
  logic [7:0]      resp_data_q;

  function automatic logic [IDW-1:0] wrap_add(logic [IDW-1:0] p, int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return s[IDW-1:0];
  endfunction

  assign stall = resp_valid_q & ~bus.resp_ready;

  // Grant depends only on req_valid and the pointer; req_x never feeds req_ready.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    accept   = 1'b0;
    if (!stall) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (!accept && bus.req_valid[wrap_add(ptr_q, k)]) begin
          accept   = 1'b1;
          grant_id = wrap_add(ptr_q, k);
        end
      end
    end
    if (accept) grant[grant_id] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (32'(grant_id) == NREQ - 1) ? '0 : grant_id + IDW'(1);
  end

  assign grant_x       = bus.req_x[11*32'(grant_id) +: 11];
  assign bus.req_ready = grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_id_q      <= '0;
      lut_addr_q   <= '0;
      lut_sign_q   <= 1'b0;
      lut_ovf_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (!stall) begin
        s1_valid_q <= accept;
        if (accept) begin
          s1_id_q    <= grant_id;
          lut_addr_q <= grant_x[8:0];
          lut_sign_q <= grant_x[10];
          // Overflow when the top two bits disagree: x outside [-512, 511].
          lut_ovf_q  <= grant_x[10] ^ grant_x[9];
        end
        resp_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          resp_id_q   <= s1_id_q;
          resp_data_q <= lut_data;
        end
      end
    end
  end

  assign lut_addr       = lut_addr_q;
  assign lut_sign       = lut_sign_q;
  assign lut_ovf        = lut_ovf_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_data  = resp_data_q;
  assign busy           = s1_valid_q | resp_valid_q;

endmodule

// File: tb/tb_siu_arbiter.sv
// Scoreboard bench for siu_arbiter: accepts push expected results, a monitor pops on
// every response; directed checks cover encoding, fairness, backpressure and reset.
module tb_siu_arbiter;
  localparam int unsigned NREQ       = 4;
  localparam int unsigned IDW        = 2;
  localparam int unsigned TOTAL_RESP = 2065;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] lut_addr;
  logic       lut_sign;
  logic       lut_ovf;
  logic [7:0] lut_data;
  logic       busy;

  int checks    = 0;
  int failures  = 0;
  int resp_cnt  = 0;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [7:0]     data;
  } exp_t;
  exp_t sb[$];

  siu_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  siu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .lut_addr (lut_addr),
    .lut_sign (lut_sign),
    .lut_ovf  (lut_ovf),
    .lut_data (lut_data),
    .busy     (busy)
  );

  // Stand-in LUT: any injective-enough function of the three inputs.
  function automatic logic [7:0] lut_model(logic [8:0] a, logic s, logic o);
    return a[8:1] ^ {s, o, 5'b0, a[0]};
  endfunction

  function automatic logic [7:0] expect_data(logic [10:0] x);
    return lut_model(x[8:0], x[10], x[10] ^ x[9]);
  endfunction

  assign lut_data = lut_model(lut_addr, lut_sign, lut_ovf);

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_x(int i, logic [10:0] v);
    bus.req_x[11*i +: 11] = v;
  endtask

  // Recorder: every handshake pushes its expected response.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          e.id   = IDW'(i);
          e.data = expect_data(bus.req_x[11*i +: 11]);
          sb.push_back(e);
        end
      end
    end
  end

  // Monitor: every delivered response pops and compares.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.resp_valid && bus.resp_ready) begin
      resp_cnt++;
      check("resp_pending", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("resp_id", 32'(bus.resp_id), 32'(e.id));
        check("resp_data", 32'(bus.resp_data), 32'(e.data));
      end
    end
  end

  initial begin
    logic [10:0] xv;
    logic [10:0] b4;
    bus.req_valid  = '0;
    bus.req_x      = '0;
    bus.resp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_id", 32'(bus.resp_id), 32'd0);
    check("rst_resp_data", 32'(bus.resp_data), 32'd0);
    check("rst_lut_addr", 32'(lut_addr), 32'd0);
    check("rst_lut_sign", 32'(lut_sign), 32'd0);
    check("rst_lut_ovf", 32'(lut_ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    cyc();
    rst = 1'b0;

    // 1: single request, x = -511
    set_x(0, 11'h601);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    check("t1_grant", 32'(bus.req_ready), 32'(4'b0001));
    cyc();
    bus.req_valid = 4'b0000;
    @(negedge clk);
    check("t1_lut_addr", 32'(lut_addr), 32'h001);
    check("t1_lut_sign", 32'(lut_sign), 32'd1);
    check("t1_lut_ovf", 32'(lut_ovf), 32'd0);
    cyc();
    @(negedge clk);
    check("t1_resp_valid", 32'(bus.resp_valid), 32'd1);
    check("t1_resp_id", 32'(bus.resp_id), 32'd0);
    check("t1_resp_data", 32'(bus.resp_data), 32'h81);
    cyc();

    // 2: full encoding sweep, one accept per clock from requester 1
    bus.req_valid = 4'b0010;
    for (int v = -1024; v < 1024; v++) begin
      xv = 11'(v);
      set_x(1, xv);
      cyc();
      if (v == 600) begin
        check("t2_600_addr", 32'(lut_addr), 32'h058);
        check("t2_600_sign", 32'(lut_sign), 32'd0);
        check("t2_600_ovf", 32'(lut_ovf), 32'd1);
      end
      if (v == -600) begin
        check("t2_m600_addr", 32'(lut_addr), 32'h1A8);
        check("t2_m600_sign", 32'(lut_sign), 32'd1);
        check("t2_m600_ovf", 32'(lut_ovf), 32'd1);
      end
      if (v == 511) begin
        check("t2_511_addr", 32'(lut_addr), 32'h1FF);
        check("t2_511_ovf", 32'(lut_ovf), 32'd0);
      end
      if (v == -512) begin
        check("t2_m512_addr", 32'(lut_addr), 32'h000);
        check("t2_m512_sign", 32'(lut_sign), 32'd1);
        check("t2_m512_ovf", 32'(lut_ovf), 32'd0);
      end
    end
    bus.req_valid = 4'b0000;
    repeat (4) cyc();
    check("t2_idle", 32'(busy), 32'd0);

    // 3: round-robin with all four requesting, starting from pointer 0
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_x(i, 11'(i * 100 + 7));
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t3_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
      if (k >= 2) check("t3_resp_id", 32'(bus.resp_id), 32'((k - 2) % 4));
      cyc();
    end
    bus.req_valid = 4'b0000;
    repeat (4) cyc();

    // 4: three accepts from requester 3, then 5 stalled cycles
    b4 = 11'(-300);
    bus.req_valid = 4'b1000;
    set_x(3, 11'(100));
    cyc();
    set_x(3, b4);
    cyc();
    set_x(3, 11'(900));
    cyc();
    bus.req_valid  = 4'b0001;
    set_x(0, 11'(-5));
    bus.resp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_stall_ready", 32'(bus.req_ready), 32'd0);
      check("t4_stall_valid", 32'(bus.resp_valid), 32'd1);
      check("t4_stall_id", 32'(bus.resp_id), 32'd3);
      check("t4_stall_data", 32'(bus.resp_data), 32'(expect_data(b4)));
      cyc();
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("t4_release_grant", 32'(bus.req_ready), 32'(4'b0001));
    cyc();
    bus.req_valid = 4'b0000;
    repeat (5) cyc();
    check("t4_idle", 32'(busy), 32'd0);

    // 5: move pointer to 3, then sparse 0101 grants 0 then 2
    bus.req_valid = 4'b0100;
    set_x(2, 11'(-700));
    cyc();
    bus.req_valid = 4'b0000;
    cyc();
    set_x(0, 11'(1023));
    set_x(2, 11'(-1024));
    bus.req_valid = 4'b0101;
    @(negedge clk);
    check("t5_first", 32'(bus.req_ready), 32'(4'b0001));
    cyc();
    bus.req_valid = 4'b0100;
    @(negedge clk);
    check("t5_second", 32'(bus.req_ready), 32'(4'b0100));
    cyc();
    bus.req_valid = 4'b0000;
    repeat (4) cyc();

    // 6: reset with both stages full
    bus.req_valid = 4'b0010;
    set_x(1, 11'(42));
    cyc();
    set_x(1, 11'(-42));
    cyc();
    bus.req_valid = 4'b0000;
    check("t6_pre_valid", 32'(bus.resp_valid), 32'd1);
    check("t6_pre_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_async_valid", 32'(bus.resp_valid), 32'd0);
    check("t6_async_busy", 32'(busy), 32'd0);
    sb.delete();
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_no_stale", 32'(bus.resp_valid), 32'd0);
      cyc();
    end
    for (int i = 0; i < NREQ; i++) set_x(i, 11'(i * 3 + 1));
    bus.req_valid = 4'b1111;
    @(negedge clk);
    check("t6_grant", 32'(bus.req_ready), 32'(4'b0001));
    cyc();
    bus.req_valid = 4'b0000;
    repeat (4) cyc();

    check("resp_total", 32'(resp_cnt), 32'(TOTAL_RESP));
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
